// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the program-counter control, program-memory read
// port and decoder handshake seen by the fetch sequencer.
// master: the fetch unit side. slave: the surrounding PC/memory/decoder side.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] PC;
  logic              PC_en;
  logic              PC_inc;
  logic [ADDR_W-1:0] PC_load;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ir_operand;
  logic              ir_valid;
  logic              ir_ready;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    input  PC, mem_data, mem_ready, ir_ready, jump_req, jump_addr,
    output PC_en, PC_inc, PC_load, mem_addr, mem_rd, ir, ir_operand, ir_valid
  );

  modport slave (
    output PC, mem_data, mem_ready, ir_ready, jump_req, jump_addr,
    input  PC_en, PC_inc, PC_load, mem_addr, mem_rd, ir, ir_operand, ir_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer. Reads opcode (and optionally an
// operand) byte at the current PC, bumps the PC after each byte and holds the
// assembled instruction for the decoder until accepted. Jumps reload the PC
// and restart fetching at the target, dropping whatever was in flight.
// Optional feature macro: FETCH_TWO_BYTE_EN enables two-byte opcodes
// (top two opcode bits 2'b11) that fetch an operand byte in the ARG state.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPC  = 2'd1,
    ARG  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ir_q;
  logic              fetching;

  assign fetching     = (state == OPC) || (state == ARG);
  assign bus.mem_addr = bus.PC;
  assign bus.mem_rd   = fetching;
  assign bus.ir_valid = (state == HOLD);
  assign bus.ir       = ir_q;

`ifdef FETCH_TWO_BYTE_EN
  logic [DATA_W-1:0] operand_q;
  logic              two_byte;

  assign two_byte       = (bus.mem_data[DATA_W-1 -: 2] == 2'b11);
  assign bus.ir_operand = operand_q;
`else
  assign bus.ir_operand = '0;
`endif

  // PC control: a jump loads the target, otherwise each completed byte read increments; reset suppresses both.
  always_comb begin
    bus.PC_en   = 1'b0;
    bus.PC_inc  = 1'b0;
    bus.PC_load = '0;
    if (!rst) begin
      if (bus.jump_req) begin
        bus.PC_en   = 1'b1;
        bus.PC_load = bus.jump_addr;
      end else if (fetching && bus.mem_ready) begin
        bus.PC_en  = 1'b1;
        bus.PC_inc = 1'b1;
      end
    end
  end

  // Fetch sequencer: walks IDLE -> OPC (-> ARG) -> HOLD, with jumps restarting at OPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir_q  <= '0;
`ifdef FETCH_TWO_BYTE_EN
      operand_q <= '0;
`endif
    end else if (bus.jump_req) begin
      state <= OPC;
    end else begin
      case (state)
        IDLE: state <= OPC;
        OPC: begin
          if (bus.mem_ready) begin
            ir_q <= bus.mem_data;
`ifdef FETCH_TWO_BYTE_EN
            operand_q <= '0;
            state     <= two_byte ? ARG : HOLD;
`else
            state <= HOLD;
`endif
          end
        end
`ifdef FETCH_TWO_BYTE_EN
        ARG: begin
          if (bus.mem_ready) begin
            operand_q <= bus.mem_data;
            state     <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (bus.ir_ready) state <= OPC;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit from a random program image and a simple
// PC register, predicts the instruction stream by walking program memory
// from the current fetch address, and scoreboards every accepted instruction.
// Honours FETCH_TWO_BYTE_EN the same way as the design.
module tb_fetch_unit;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] opcode;
    logic [7:0] operand;
  } instr_t;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] prog [256];
  logic [7:0] pcReg;
  logic [7:0] junk;
  logic [7:0] modelPtr;
  instr_t     expQ [$];
  int         checks     = 0;
  int         errors     = 0;
  int         accepted   = 0;
  int         idleCycles = 0;

  assign bus.PC       = pcReg;
  assign bus.mem_data = bus.mem_ready ? prog[bus.mem_addr] : junk;

  // Program counter model: increments or loads under fetch_unit control.
  always @(posedge clk) begin
    if (rst) pcReg <= 8'h00;
    else if (bus.PC_en) pcReg <= bus.PC_inc ? pcReg + 8'd1 : bus.PC_load;
  end

  function automatic bit isTwoByte(input logic [7:0] op);
`ifdef FETCH_TWO_BYTE_EN
    return op[7:6] == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the instruction stream is a walk through program memory.
  function automatic void topUp();
    while (expQ.size() < 8) begin
      instr_t     e;
      logic [7:0] nextAddr;
      nextAddr  = modelPtr + 8'd1;
      e.addr    = modelPtr;
      e.opcode  = prog[modelPtr];
      if (isTwoByte(e.opcode)) begin
        e.operand = prog[nextAddr];
        modelPtr  = modelPtr + 8'd2;
      end else begin
        e.operand = 8'h00;
        modelPtr  = nextAddr;
      end
      expQ.push_back(e);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic readyV, input logic irReadyV,
                               input logic jumpV, input logic [7:0] jumpAddrV);
    @(negedge clk);
    rst           = rstV;
    bus.mem_ready = readyV;
    bus.ir_ready  = irReadyV;
    bus.jump_req  = jumpV;
    bus.jump_addr = jumpAddrV;
    junk          = 8'($urandom);
    if (rstV) begin
      expQ.delete();
      modelPtr = 8'h00;
    end else if (jumpV) begin
      expQ.delete();
      modelPtr = jumpAddrV;
    end
    topUp();
    #4;
  endtask

  // Monitor: checks per-cycle invariants and scoreboards each accepted instruction.
  initial begin
    instr_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst !== 1'b0) begin
        idleCycles = 0;
      end else begin
        checkOutput("mem_addr_tracks_pc", bus.mem_addr, pcReg);
        if (bus.ir_valid) checkOutput("hold_no_read", bus.mem_rd, 1'b0);
        if (bus.jump_req) begin
          checkOutput("jump_pc_en", bus.PC_en, 1'b1);
          checkOutput("jump_pc_inc", bus.PC_inc, 1'b0);
          checkOutput("jump_pc_load", bus.PC_load, bus.jump_addr);
          idleCycles = 0;
        end else begin
          checkOutput("pc_load_zero", bus.PC_load, 8'h00);
          if (bus.ir_valid && bus.ir_ready) begin
            accepted++;
            idleCycles = 0;
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL sb_empty: instruction 0x%0h accepted, none expected", bus.ir);
            end else begin
              e = expQ.pop_front();
              checkOutput("sb_opcode", bus.ir, e.opcode);
              checkOutput("sb_operand", bus.ir_operand, e.operand);
            end
          end else begin
            idleCycles++;
          end
        end
        if (idleCycles > 200) begin
          checks++;
          errors++;
          $display("[TB] FAIL watchdog: no instruction for %0d cycles", idleCycles);
          idleCycles = 0;
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.ir_ready  = 1'b0;
    bus.jump_req  = 1'b0;
    bus.jump_addr = 8'h00;
    junk          = 8'h00;
    modelPtr      = 8'h00;
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    prog[0] = 8'h15;
    prog[1] = 8'hC2;
    prog[2] = 8'hD9;

    $display("[TB] directed phase");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    checkOutput("reset_cycle_no_pc_en", bus.PC_en, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    checkOutput("reset_pc_en", bus.PC_en, 1'b0);
    checkOutput("reset_pc_inc", bus.PC_inc, 1'b0);
    checkOutput("reset_pc_load", bus.PC_load, 8'h00);
    checkOutput("reset_mem_rd", bus.mem_rd, 1'b0);
    checkOutput("reset_ir_valid", bus.ir_valid, 1'b0);
    checkOutput("reset_ir", bus.ir, 8'h00);
    checkOutput("reset_ir_operand", bus.ir_operand, 8'h00);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_mem_rd", bus.mem_rd, 1'b0);
    checkOutput("idle_pc_en", bus.PC_en, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("opc_mem_rd", bus.mem_rd, 1'b1);
    checkOutput("opc_addr", bus.mem_addr, 8'h00);
    checkOutput("opc_pc_en", bus.PC_en, 1'b1);
    checkOutput("opc_pc_inc", bus.PC_inc, 1'b1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("bp_ir_valid", bus.ir_valid, 1'b1);
      checkOutput("bp_ir", bus.ir, 8'h15);
      checkOutput("bp_ir_operand", bus.ir_operand, 8'h00);
      checkOutput("bp_mem_rd", bus.mem_rd, 1'b0);
      checkOutput("bp_pc_en", bus.PC_en, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("accept_ir_valid", bus.ir_valid, 1'b1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("wait_mem_rd", bus.mem_rd, 1'b1);
      checkOutput("wait_addr", bus.mem_addr, 8'h01);
      checkOutput("wait_pc_en", bus.PC_en, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("wait_done_pc_en", bus.PC_en, 1'b1);
    checkOutput("wait_done_addr", bus.mem_addr, 8'h01);

`ifdef FETCH_TWO_BYTE_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("arg_mem_rd", bus.mem_rd, 1'b1);
    checkOutput("arg_addr", bus.mem_addr, 8'h02);
    checkOutput("arg_pc_en", bus.PC_en, 1'b1);
    checkOutput("arg_ir_valid", bus.ir_valid, 1'b0);
`endif

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hD9);
    checkOutput("two_byte_ir_valid", bus.ir_valid, 1'b1);
    checkOutput("two_byte_ir", bus.ir, 8'hC2);
`ifdef FETCH_TWO_BYTE_EN
    checkOutput("two_byte_operand", bus.ir_operand, 8'hD9);
`else
    checkOutput("two_byte_operand", bus.ir_operand, 8'h00);
`endif
    checkOutput("hold_jump_pc_en", bus.PC_en, 1'b1);
    checkOutput("hold_jump_pc_inc", bus.PC_inc, 1'b0);
    checkOutput("hold_jump_pc_load", bus.PC_load, 8'hD9);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("post_jump_ir_valid", bus.ir_valid, 1'b0);
    checkOutput("post_jump_mem_rd", bus.mem_rd, 1'b1);
    checkOutput("post_jump_addr", bus.mem_addr, 8'hD9);

    $display("[TB] random phase");
    accepted = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rV, jV;
      rV = ($urandom_range(0, 299) == 0);
      jV = ($urandom_range(0, 19) == 0);
      applyStimulus(rV, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), jV,
                    8'($urandom));
      if (rV) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("midrst_ir_valid", bus.ir_valid, 1'b0);
        checkOutput("midrst_mem_rd", bus.mem_rd, 1'b0);
        checkOutput("midrst_ir", bus.ir, 8'h00);
      end
    end
    checkOutput("random_progress", (accepted > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8-bit microprocessor, sitting directly downstream of the program counter and upstream of the instruction decoder. It reads the current PC, issues byte reads to program memory, assembles one- or two-byte instructions, and presents them to the decoder through a valid/ready handshake. It drives the program counter's increment and load controls, including redirects on jump requests from the decoder.

## Interface
- `ADDR_W`, default 8: program-memory address width; equals the PC width.
- `DATA_W`, default 8: instruction byte width.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PC` in ADDR_W: current program counter value.
- `PC_en` out 1: PC update enable.
- `PC_inc` out 1: with `PC_en`=1, 1 increments the PC and 0 loads `PC_load`.
- `PC_load` out ADDR_W: PC load value.
- `mem_addr` out ADDR_W: memory read address, always equal to `PC`.
- `mem_rd` out 1: read request.
- `mem_data` in DATA_W: read data, valid when `mem_ready`=1.
- `mem_ready` in 1: read completes this cycle.
- `ir` out DATA_W: opcode byte.
- `ir_operand` out DATA_W: operand byte for two-byte instructions, otherwise 0.
- `ir_valid` out 1: `ir`/`ir_operand` hold a complete instruction.
- `ir_ready` in 1: decoder accepts the instruction.
- `jump_req` in 1: redirect fetch.
- `jump_addr` in ADDR_W: redirect target.

## Operation
- States: IDLE, OPC (fetch opcode), ARG (fetch operand), HOLD (present to decoder).
- Reset: state IDLE. `PC_en`=0, `PC_inc`=0, `PC_load`=0, `mem_rd`=0, `ir_valid`=0, `ir`=0, `ir_operand`=0. `rst` overrides every other input.
- IDLE:
  - Always moves to OPC on the next cycle.
  - `mem_rd`=0.
- OPC:
  - `mem_rd`=1.
  - When `mem_ready`=1: latch `mem_data` into `ir`, clear `ir_operand`, and drive `PC_en`=1, `PC_inc`=1 in the same cycle.
  - Go to ARG if `mem_data[7:6]`=2'b11 (two-byte opcode); otherwise go to HOLD.
  - When `mem_ready`=0: hold all state and issue no PC update.
- ARG:
  - `mem_rd`=1.
  - When `mem_ready`=1: latch `mem_data` into `ir_operand`, drive `PC_en`=1, `PC_inc`=1, then go to HOLD.
- HOLD:
  - `ir_valid`=1 and `mem_rd`=0.
  - `ir`/`ir_operand` stay stable until accepted.
  - On `ir_ready`=1, the instruction is consumed and the state goes to OPC.
- Jump (any non-reset state, including IDLE):
  - Drive `PC_en`=1, `PC_inc`=0, `PC_load`=`jump_addr` for exactly that cycle, then go to OPC next cycle.
  - Any byte returned that cycle is discarded.
  - `ir_valid` falls next cycle. An instruction in HOLD is dropped even if `ir_ready`=1 in the same cycle.
- Priority: `rst` > `jump_req` > `mem_ready`/`ir_ready`.
- `PC_en`, `PC_inc`, `PC_load`: combinational decode of state plus inputs. Outside the cases above they are 0, 0, 0.
- `ir_valid`: decoded from state HOLD. `ir`/`ir_operand`: registers.
- PC wrap-around (0xFF→0x00) is owned by the counter; `fetch_unit` does not treat it specially.

## Timing
- The PC update issued in cycle n is visible on `PC`/`mem_addr` in cycle n+1. The next read therefore always uses the updated address.
- Single-byte latency: OPC with `mem_ready`=1 in cycle n gives `ir_valid`=1 in cycle n+1.
- Two-byte latency: `mem_ready` high in cycles n and n+1 gives `ir_valid` in cycle n+2.
- Throughput: `ir_ready` sampled high in cycle m puts the state in OPC in cycle m+1. Minimum 2 cycles per single-byte instruction with zero-wait memory.
- Memory wait states extend OPC/ARG one cycle per `mem_ready`=0, with no side effects.
- Reset mid-fetch: the next cycle is IDLE with all outputs at reset values. No PC update is issued in the reset cycle.

## Configuration
- `FETCH_TWO_BYTE_EN`:
  - Defined: two-byte opcodes (`[7:6]`=2'b11) enter ARG as described.
  - Undefined: ARG is not compiled. Every opcode goes OPC→HOLD and `ir_operand` is constantly 0.

## Test plan
- Reset: assert `rst` for 2 cycles with `mem_ready`=1 and `jump_req`=1 → all outputs at reset values, no `PC_en` pulse; state reaches OPC 2 cycles after release.
- Single-byte fetch: `PC`=0x00, `mem_data`=0x15, `mem_ready`=1 → one `PC_en`=1/`PC_inc`=1 pulse, then `ir_valid`=1, `ir`=0x15, `ir_operand`=0x00. `ir_ready`=1 → next read at 0x01.
- Two-byte fetch (macro defined): bytes 0xC2 then 0xD9 → two increment pulses, then `ir`=0xC2, `ir_operand`=0xD9. With the macro undefined → `ir`=0xC2, `ir_operand`=0x00, one pulse.
- Back-pressure: `ir_ready`=0 for 5 cycles → `ir_valid` stays 1, `ir` stable, `mem_rd`=0, no `PC_en`.
- Wait states: `mem_ready` low for 3 cycles in OPC → `mem_rd` held high, no PC pulse, byte latched on the 4th cycle.
- Jump during HOLD with `ir_ready`=1, `jump_addr`=0xD9 → `PC_en`=1, `PC_inc`=0, `PC_load`=0xD9 that cycle; `ir_valid`=0 next cycle; next read address 0xD9.
